chan_mux_arb: RTL

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output, and a registered output stage. It has two modes: direct select, driven by an external channel index, and round-robin arbitration among the valid inputs. It sits between multiple producer channels (peripheral/datapath sources) and a single consumer such as the output pin driver or the serialiser.

---
 rtl/chan_mux_arb.sv | 97 +++++++++
 1 files changed

// File: rtl/chan_mux_arb.sv
// N-channel stream multiplexer with direct-select and round-robin modes,
// valid/ready handshakes and a single registered output stage.
module chan_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_can_load;
  logic             w_found;
  logic [SEL_W-1:0] w_grant;
  logic             w_load;
  logic [SEL_W-1:0] w_rr_next;
  logic [WIDTH-1:0] w_mux_data;

  assign w_can_load = !r_out_valid || out_ready;

  // Grant depends only on mode, sel, in_valid and the pointer, never on data.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_grant = '0;
    if (!mode) begin
      // Scanning the legal indices means sel >= CHANNELS simply never matches.
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_found = 1'b1;
          w_grant = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!w_found && in_valid[idx]) begin
          w_found = 1'b1;
          w_grant = SEL_W'(idx);
        end
      end
    end
  end

  assign w_load    = w_can_load && w_found && !rst;
  assign w_rr_next = (int'(w_grant) == CHANNELS - 1) ? '0 : w_grant + 1'b1;

  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) w_mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready[gi] = w_load && (w_grant == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_data  <= w_mux_data;
      r_out_chan  <= w_grant;
      r_out_valid <= 1'b1;
      if (mode) r_rr_ptr <= w_rr_next;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
